// File: rtl/r2sdf_stage_ctrl_pkg.sv
// rtl/r2sdf_stage_ctrl_pkg.sv - shared FSM encoding and width helper for the R2SDF stage sequencer
package r2sdf_stage_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Zero-width vectors are illegal, so a zero log-depth still gets one bit
  function automatic int min_width(input int w);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/r2sdf_stage_ctrl_if.sv
// rtl/r2sdf_stage_ctrl_if.sv - sample handshake and stage control bundle between upstream, datapath and sequencer
interface r2sdf_stage_ctrl_if #(
  parameter int LOG2_N = 6
);
  logic              di_en;
  logic              di_rdy;
  logic              bf_sel;
  logic              do_en;
  logic              tw_en;
  logic [LOG2_N-2:0] tw_addr;
  logic              frame_st;
  logic              frame_dn;
  logic              err;

  modport master (
    output di_en,
    input  di_rdy, bf_sel, do_en, tw_en, tw_addr, frame_st, frame_dn, err
  );

  modport slave (
    input  di_en,
    output di_rdy, bf_sel, do_en, tw_en, tw_addr, frame_st, frame_dn, err
  );
endinterface

// File: rtl/r2sdf_mod_cnt.sv
// rtl/r2sdf_mod_cnt.sv - modulo 2**W counter with enable, sync clear, async reset and wrap strobe
module r2sdf_mod_cnt #(
  parameter int W = 6
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_wrap = i_en & (&r_cnt);
endmodule

// File: rtl/r2sdf_stage_ctrl.sv
// rtl/r2sdf_stage_ctrl.sv - sequencer for one R2SDF FFT stage (delay D = 2**(LOG2_N-1-STAGE))
// Optional mid-frame gap checking with sticky err: define R2SDF_CTRL_CHK_EN.
module r2sdf_stage_ctrl
  import r2sdf_stage_ctrl_pkg::*;
#(
  parameter int LOG2_N = 6,
  parameter int STAGE  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  r2sdf_stage_ctrl_if.slave bus
);
  localparam int LOGD = LOG2_N - 1 - STAGE;
  localparam int D    = 1 << LOGD;
  localparam int DW   = min_width(LOGD);
  localparam int TW   = LOG2_N - 1;

  state_t            r_state;
  state_t            w_next;
  logic [LOG2_N-1:0] w_in_cnt;
  logic [LOG2_N-1:0] w_out_cnt;
  logic [DW-1:0]     r_drn;
  logic              r_bound;
  logic              w_in_wrap;
  logic              w_out_wrap;
  logic              w_acc;
  logic              w_clr;
  logic              w_load_drn;
  logic              w_rdy;
  logic              w_do_en;
  logic [TW-1:0]     w_tw_addr;

`ifdef R2SDF_CTRL_CHK_EN
  logic w_gap;
  logic r_err;

  // A missing sample anywhere except the frame boundary is a gap
  assign w_gap = ~bus.di_en & ((r_state == ST_FILL) | ((r_state == ST_RUN) & ~r_bound));
  assign w_clr = w_gap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_gap) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  assign w_clr   = 1'b0;
  assign bus.err = 1'b0;
`endif

  assign w_acc = bus.di_en & w_rdy;

  r2sdf_mod_cnt #(.W(LOG2_N)) u_in_cnt (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clr   (w_clr),
    .i_en    (w_acc),
    .o_cnt   (w_in_cnt),
    .o_wrap  (w_in_wrap)
  );

  r2sdf_mod_cnt #(.W(LOG2_N)) u_out_cnt (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clr   (w_clr),
    .i_en    (w_do_en),
    .o_cnt   (w_out_cnt),
    .o_wrap  (w_out_wrap)
  );

  always_comb begin
    w_next     = r_state;
    w_rdy      = 1'b1;
    w_do_en    = 1'b0;
    w_load_drn = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.di_en) w_next = (D > 1) ? ST_FILL : ST_RUN;
      end
      ST_FILL: begin
        if (bus.di_en && (w_in_cnt == LOG2_N'(D - 1))) w_next = ST_RUN;
      end
      ST_RUN: begin
        w_do_en = 1'b1;
        if (!bus.di_en && r_bound) begin
          w_next     = (D > 1) ? ST_DRAIN : ST_IDLE;
          w_load_drn = 1'b1;
        end
      end
      ST_DRAIN: begin
        w_rdy   = 1'b0;
        w_do_en = 1'b1;
        if (r_drn == DW'(1)) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
`ifdef R2SDF_CTRL_CHK_EN
    if (w_gap) begin
      w_next  = ST_IDLE;
      w_do_en = 1'b0;
    end
`endif
  end

  // r_bound mirrors in_cnt==0 after a completed input frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_drn   <= '0;
      r_bound <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load_drn) begin
        r_drn <= DW'(D - 1);
      end else if (r_state == ST_DRAIN) begin
        r_drn <= r_drn - DW'(1);
      end
      if (w_clr) begin
        r_bound <= 1'b0;
      end else if (w_in_wrap) begin
        r_bound <= 1'b1;
      end else if (w_acc) begin
        r_bound <= 1'b0;
      end
    end
  end

  generate
    if (LOGD == 0) begin : g_tw_zero
      assign w_tw_addr = '0;
    end else begin : g_tw_idx
      assign w_tw_addr = TW'(w_out_cnt[LOGD-1:0]) << STAGE;
    end
  endgenerate

  assign bus.di_rdy   = w_rdy;
  assign bus.do_en    = w_do_en;
  assign bus.bf_sel   = w_acc & w_in_cnt[LOGD];
  assign bus.tw_en    = w_do_en & w_out_cnt[LOGD];
  assign bus.tw_addr  = w_tw_addr;
  assign bus.frame_st = w_do_en & (w_out_cnt == '0);
  assign bus.frame_dn = w_out_wrap;
endmodule

// File: tb/tb_r2sdf_stage_ctrl.sv
// tb/tb_r2sdf_stage_ctrl.sv - directed bench for the R2SDF stage sequencer at N=16, stages 0, 1 and 3
module tb_r2sdf_stage_ctrl;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  r2sdf_stage_ctrl_if #(.LOG2_N(4)) if0 ();
  r2sdf_stage_ctrl_if #(.LOG2_N(4)) if1 ();
  r2sdf_stage_ctrl_if #(.LOG2_N(4)) if3 ();

  r2sdf_stage_ctrl #(.LOG2_N(4), .STAGE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  r2sdf_stage_ctrl #(.LOG2_N(4), .STAGE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  r2sdf_stage_ctrl #(.LOG2_N(4), .STAGE(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  task automatic test_reset();
    logic [9:0] obs;
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    obs = {if0.di_rdy, if0.do_en, if0.bf_sel, if0.tw_en, if0.frame_st, if0.frame_dn, if0.err, if0.tw_addr};
    total++;
    if (obs !== 10'b1000000_000) begin bad++; $display("FAIL reset_s0 got=%b want=%b", obs, 10'b1000000_000); end
    obs = {if1.di_rdy, if1.do_en, if1.bf_sel, if1.tw_en, if1.frame_st, if1.frame_dn, if1.err, if1.tw_addr};
    total++;
    if (obs !== 10'b1000000_000) begin bad++; $display("FAIL reset_s1 got=%b want=%b", obs, 10'b1000000_000); end
    obs = {if3.di_rdy, if3.do_en, if3.bf_sel, if3.tw_en, if3.frame_st, if3.frame_dn, if3.err, if3.tw_addr};
    total++;
    if (obs !== 10'b1000000_000) begin bad++; $display("FAIL reset_s3 got=%b want=%b", obs, 10'b1000000_000); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // D=8, one 16-sample frame starting at t=0
  task automatic test_frame16(input logic exp_err, input string tag);
    logic [6:0] obs, exp;
    for (int t = -2; t <= 26; t++) begin
      @(negedge clk);
      if0.di_en = (t >= 0 && t <= 15);
      #1;
      exp = {!(t >= 17 && t <= 23), (t >= 8 && t <= 23), (t >= 8 && t <= 15),
             (t >= 16 && t <= 23), (t == 8), (t == 23), exp_err};
      obs = {if0.di_rdy, if0.do_en, if0.bf_sel, if0.tw_en, if0.frame_st, if0.frame_dn, if0.err};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL %s t=%0d flags got=%b want=%b", tag, t, obs, exp); end
      if (t >= 16 && t <= 23) begin
        total++;
        if (if0.tw_addr !== 3'(t - 16)) begin
          bad++; $display("FAIL %s_tw_addr t=%0d got=%0d want=%0d", tag, t, if0.tw_addr, t - 16);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] obs, exp;
    logic       d, tw;
    for (int t = -1; t <= 42; t++) begin
      @(negedge clk);
      if0.di_en = (t >= 0 && t <= 31);
      #1;
      d   = (t >= 8 && t <= 39);
      tw  = d && (((t - 8) % 16) >= 8);
      exp = {!(t >= 33 && t <= 39), d, (t >= 0 && t <= 31 && (t % 16) >= 8), tw,
             (t == 8 || t == 24), (t == 23 || t == 39), 1'b0};
      obs = {if0.di_rdy, if0.do_en, if0.bf_sel, if0.tw_en, if0.frame_st, if0.frame_dn, if0.err};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL b2b t=%0d flags got=%b want=%b", t, obs, exp); end
      if (tw) begin
        total++;
        if (if0.tw_addr !== 3'((t - 8) % 8)) begin
          bad++; $display("FAIL b2b_tw_addr t=%0d got=%0d want=%0d", t, if0.tw_addr, (t - 8) % 8);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] obs;
    for (int t = -1; t <= 11; t++) begin
      @(negedge clk);
      if0.di_en = (t >= 0);
    end
    #1;
    total++;
    if (if0.do_en !== 1'b1) begin bad++; $display("FAIL mid_run_do_en got=%b want=1", if0.do_en); end
    @(negedge clk);
    if0.di_en = 1'b0;
    rst_n     = 1'b0;
    #1;
    obs = {if0.di_rdy, if0.do_en, if0.bf_sel, if0.tw_en, if0.frame_st, if0.frame_dn, if0.err, if0.tw_addr};
    total++;
    if (obs !== 10'b1000000_000) begin bad++; $display("FAIL async_reset got=%b want=%b", obs, 10'b1000000_000); end
    @(negedge clk);
    #1;
    total++;
    if (if0.frame_dn !== 1'b0) begin bad++; $display("FAIL reset_no_dn got=%b want=0", if0.frame_dn); end
    rst_n = 1'b1;
    test_frame16(1'b0, "after_reset");
  endtask

  // D=1: output is the accepted input delayed one cycle, frames separated by random gaps
  task automatic test_last_stage();
    bit         sched[$];
    logic [9:0] obs, exp;
    logic [3:0] k, prev_k;
    logic       prev_acc;
    for (int f = 0; f < 4; f++) begin
      repeat ($urandom_range(0, 2)) sched.push_back(1'b0);
      repeat (16) sched.push_back(1'b1);
    end
    repeat (3) sched.push_back(1'b0);
    k        = '0;
    prev_k   = '0;
    prev_acc = 1'b0;
    foreach (sched[i]) begin
      @(negedge clk);
      if3.di_en = sched[i];
      #1;
      exp = {1'b1, prev_acc, sched[i] & k[0], prev_acc & prev_k[0],
             prev_acc && (prev_k == 4'd0), prev_acc && (prev_k == 4'd15), 1'b0, 3'b000};
      obs = {if3.di_rdy, if3.do_en, if3.bf_sel, if3.tw_en, if3.frame_st, if3.frame_dn, if3.err, if3.tw_addr};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL last_stage i=%0d got=%b want=%b", i, obs, exp); end
      prev_acc = sched[i];
      prev_k   = k;
      if (sched[i]) k = k + 4'd1;
    end
  endtask

  task automatic test_stage1();
    logic [6:0] obs, exp;
    logic       d, tw;
    for (int t = -1; t <= 22; t++) begin
      @(negedge clk);
      if1.di_en = (t >= 0 && t <= 15);
      #1;
      d   = (t >= 4 && t <= 19);
      tw  = d && (((t - 4) % 8) >= 4);
      exp = {!(t >= 17 && t <= 19), d, (t >= 0 && t <= 15 && (t % 8) >= 4), tw,
             (t == 4), (t == 19), 1'b0};
      obs = {if1.di_rdy, if1.do_en, if1.bf_sel, if1.tw_en, if1.frame_st, if1.frame_dn, if1.err};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL stage1 t=%0d flags got=%b want=%b", t, obs, exp); end
      if (tw) begin
        total++;
        if (if1.tw_addr !== 3'(((t - 4) % 4) * 2)) begin
          bad++; $display("FAIL stage1_tw_addr t=%0d got=%0d want=%0d", t, if1.tw_addr, ((t - 4) % 4) * 2);
        end
      end
    end
  endtask

`ifdef R2SDF_CTRL_CHK_EN
  task automatic test_gap_check();
    logic [6:0] obs, exp;
    for (int t = -1; t <= 8; t++) begin
      @(negedge clk);
      if0.di_en = (t >= 0 && t <= 4);
      #1;
      exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (t >= 6)};
      obs = {if0.di_rdy, if0.do_en, if0.bf_sel, if0.tw_en, if0.frame_st, if0.frame_dn, if0.err};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL gap t=%0d flags got=%b want=%b", t, obs, exp); end
    end
    test_frame16(1'b1, "post_gap");
  endtask
`endif

  initial begin
    if0.di_en = 1'b0;
    if1.di_en = 1'b0;
    if3.di_en = 1'b0;
    test_reset();
    test_frame16(1'b0, "frame16");
    test_back_to_back();
    test_reset_mid();
    test_last_stage();
    test_stage1();
`ifdef R2SDF_CTRL_CHK_EN
    test_gap_check();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
